// File: rtl/uart_rx_pkg.sv
// Shared types and register map for the uart_rx_port receiver.
// Optional parity support is selected with UART_RX_PARITY_EN.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;

  localparam int ST_NEMPTY = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVR    = 2;
  localparam int ST_FERR   = 3;
  localparam int ST_PERR   = 4;

  localparam int CTL_EN     = 0;
  localparam int CTL_IRQ_EN = 1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with show-ahead read data; a push while full is
// accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = ((wp ^ rp) == {1'b1, {AW{1'b0}}});
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_port.sv
// Port-mapped 8N1 UART receiver with 16x oversampling, receive FIFO and irq.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_port
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQ = 10000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        uart_rx,
  input  logic [1:0]  ADDRESS,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  input  logic        memWR,
  input  logic        memRD,
  output logic        irq
);

  localparam int TICK_RAW = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  rx_state_t        state;
  logic             rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             push_req, ferr_set, perr_set;
  logic             ctrl_en, ctrl_irq_en;
  logic             ovr, ferr, perr;
  logic [7:0]       fifo_dout;
  logic             fifo_full, fifo_empty, fifo_pop, ovr_set;
  logic             rd_data, wr_status, wr_control;
  logic [10:0]      unused_data_in;

  assign tick           = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign rd_data        = memRD & (ADDRESS == REG_DATA);
  assign wr_status      = memWR & (ADDRESS == REG_STATUS);
  assign wr_control     = memWR & (ADDRESS == REG_CONTROL);
  assign fifo_pop       = rd_data & ~fifo_empty;
  assign ovr_set        = push_req & fifo_full & ~fifo_pop;
  assign unused_data_in = DATA_IN[15:5];

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // tick_cnt counts ticks within the current bit; it wraps 15->0 at each bit centre.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      push_req <= 1'b0;
      ferr_set <= 1'b0;
      perr_set <= 1'b0;
    end else begin
      push_req <= 1'b0;
      ferr_set <= 1'b0;
      perr_set <= 1'b0;
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
      if (!ctrl_en) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (rx_prev && !rx_s) begin
            state    <= S_START;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
          S_START: if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? S_IDLE : S_DATA;
            end
          end
          S_DATA: if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd15) begin
              shreg   <= {rx_s, shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
              if (bit_cnt == 3'd7) state <= S_PARITY;
`else
              if (bit_cnt == 3'd7) state <= S_STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd15) begin
              perr_set <= ^{shreg, rx_s};
              state    <= S_STOP;
            end
          end
`endif
          S_STOP: if (tick) begin
            tick_cnt <= tick_cnt + 1'b1;
            if (tick_cnt == 4'd15) begin
              if (rx_s) begin
                push_req <= 1'b1;
                state    <= S_IDLE;
              end else begin
                ferr_set <= 1'b1;
                state    <= S_BREAK;
              end
            end
          end
          S_BREAK: if (rx_s) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (CLK),
    .rstb    (RSTb),
    .push    (push_req),
    .wr_data (shreg),
    .pop     (fifo_pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Sticky flags: a same-cycle set wins over a write-one-to-clear.
  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovr         <= 1'b0;
      ferr        <= 1'b0;
      perr        <= 1'b0;
      DATA_OUT    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_control) begin
        ctrl_en     <= DATA_IN[CTL_EN];
        ctrl_irq_en <= DATA_IN[CTL_IRQ_EN];
      end
      ovr  <= (ovr  & ~(wr_status & DATA_IN[ST_OVR]))  | ovr_set;
      ferr <= (ferr & ~(wr_status & DATA_IN[ST_FERR])) | ferr_set;
      perr <= (perr & ~(wr_status & DATA_IN[ST_PERR])) | perr_set;
      if (memRD) begin
        case (ADDRESS)
          REG_DATA:    DATA_OUT <= fifo_empty ? '0 : {7'b0, 1'b1, fifo_dout};
          REG_STATUS:  DATA_OUT <= {11'b0, perr, ferr, ovr, fifo_full, ~fifo_empty};
          REG_CONTROL: DATA_OUT <= {14'b0, ctrl_irq_en, ctrl_en};
          default:     DATA_OUT <= '0;
        endcase
      end
      irq <= ctrl_en & ctrl_irq_en & (~fifo_empty | ovr | ferr | perr);
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: 1 tick per clk, 16 clks per bit.
// Build with UART_RX_PARITY_EN defined to also exercise the parity path.
module tb_uart_rx_port;

  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        uart_rx = 1'b1;
  logic [1:0]  ADDRESS = '0;
  logic [15:0] DATA_IN = '0;
  logic [15:0] DATA_OUT;
  logic        memWR = 1'b0;
  logic        memRD = 1'b0;
  logic        irq;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic        en_model = 1'b0;
  logic [15:0] rd;

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    logic [15:0] exp_status;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[5];

  uart_rx_port #(
    .CLOCK_FREQ (1600000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RSTb     (RSTb),
    .uart_rx  (uart_rx),
    .ADDRESS  (ADDRESS),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .memWR    (memWR),
    .memRD    (memRD),
    .irq      (irq)
  );

  always #5 CLK = ~CLK;

  task automatic clks(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [15:0] v);
    ADDRESS = a;
    memRD   = 1'b1;
    clks(1);
    memRD   = 1'b0;
    v       = DATA_OUT;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] v);
    ADDRESS = a;
    DATA_IN = v;
    memWR   = 1'b1;
    if (a == 2'd2) en_model = v[0];
    clks(1);
    memWR   = 1'b0;
    DATA_IN = '0;
  endtask

  // Scoreboard: good frames arriving while enabled and with room are expected back.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par);
    logic [10:0] frame;
    int unsigned nbits;
    frame = PAR_EN ? {stop, par, d, 1'b0} : {par, stop, d, 1'b0};
    nbits = PAR_EN ? 11 : 10;
    for (int unsigned i = 0; i < nbits; i++) begin
      uart_rx = frame[i];
      clks(16);
    end
    uart_rx = 1'b1;
    clks(6);
    if (stop && en_model && exp_q.size() < DEPTH) exp_q.push_back({7'b0, 1'b1, d});
  endtask

  task automatic read_data_check(input string name);
    logic [15:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
    reg_read(2'd0, rd);
    check(name, rd, exp);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 16'h0001, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 16'h0001, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 16'h0001, 1'b1};
    vecs[3] = '{8'h3C, 1'b0, 16'h0008, 1'b1};
    vecs[4] = '{8'h81, 1'b1, 16'h0001, 1'b1};

    clks(3);
    check("reset DATA_OUT", DATA_OUT, 16'h0000);
    check("reset irq", {15'b0, irq}, 16'h0000);
    RSTb = 1'b1;
    clks(2);
    reg_read(2'd1, rd);
    check("reset STATUS", rd, 16'h0000);
    reg_read(2'd2, rd);
    check("reset CONTROL", rd, 16'h0000);

    reg_write(2'd2, 16'h0003);
    reg_read(2'd2, rd);
    check("CONTROL readback", rd, 16'h0003);

    foreach (vecs[k]) begin
      send_byte(vecs[k].d, vecs[k].stop, ^vecs[k].d);
      reg_read(2'd1, rd);
      check($sformatf("vec%0d STATUS", k), rd, vecs[k].exp_status);
      check($sformatf("vec%0d irq", k), {15'b0, irq}, {15'b0, vecs[k].exp_irq});
      read_data_check($sformatf("vec%0d DATA", k));
      reg_write(2'd1, 16'h001C);
      clks(2);
      reg_read(2'd1, rd);
      check($sformatf("vec%0d STATUS after", k), rd, 16'h0000);
      check($sformatf("vec%0d irq after", k), {15'b0, irq}, 16'h0000);
    end

    // Overflow: 17 bytes into a 16-entry FIFO.
    for (int unsigned i = 0; i < 17; i++) send_byte(8'(i), 1'b1, ^8'(i));
    reg_read(2'd1, rd);
    check("ovf STATUS", rd, 16'h0007);
    for (int unsigned i = 0; i < 17; i++) read_data_check($sformatf("ovf DATA%0d", i));
    reg_read(2'd1, rd);
    check("ovf STATUS drained", rd, 16'h0004);
    reg_write(2'd1, 16'h0004);
    reg_read(2'd1, rd);
    check("ovf cleared", rd, 16'h0000);

    // Framing error, then a good frame; ferr stays sticky.
    send_byte(8'h3C, 1'b0, ^8'h3C);
    reg_read(2'd1, rd);
    check("ferr STATUS", rd, 16'h0008);
    send_byte(8'h3C, 1'b1, ^8'h3C);
    reg_read(2'd1, rd);
    check("ferr+data STATUS", rd, 16'h0009);
    read_data_check("ferr good DATA");
    reg_read(2'd1, rd);
    check("ferr sticky", rd, 16'h0008);
    reg_write(2'd1, 16'h0008);
    reg_read(2'd1, rd);
    check("ferr cleared", rd, 16'h0000);

    // Start-bit glitch is rejected and the receiver stays usable.
    uart_rx = 1'b0;
    clks(4);
    uart_rx = 1'b1;
    clks(200);
    reg_read(2'd1, rd);
    check("glitch STATUS", rd, 16'h0000);
    read_data_check("glitch DATA");
    send_byte(8'h5A, 1'b1, ^8'h5A);
    read_data_check("post-glitch DATA");

    // Reset mid-frame with a byte already buffered.
    send_byte(8'h11, 1'b1, ^8'h11);
    uart_rx = 1'b0;
    clks(16);
    for (int unsigned i = 0; i < 3; i++) begin
      uart_rx = i[0] ? 1'b0 : 1'b1;
      clks(16);
    end
    RSTb = 1'b0;
    clks(2);
    check("midreset DATA_OUT", DATA_OUT, 16'h0000);
    check("midreset irq", {15'b0, irq}, 16'h0000);
    uart_rx = 1'b1;
    RSTb = 1'b1;
    exp_q.delete();
    en_model = 1'b0;
    clks(200);
    reg_read(2'd1, rd);
    check("postreset STATUS", rd, 16'h0000);
    reg_read(2'd2, rd);
    check("postreset CONTROL", rd, 16'h0000);
    send_byte(8'h55, 1'b1, ^8'h55);
    reg_read(2'd1, rd);
    check("disabled STATUS", rd, 16'h0000);
    reg_write(2'd2, 16'h0003);
    send_byte(8'h55, 1'b1, ^8'h55);
    read_data_check("reenabled DATA");

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b0);
    reg_read(2'd1, rd);
    check("perr STATUS", rd, 16'h0011);
    read_data_check("perr DATA");
    reg_write(2'd1, 16'h0010);
    send_byte(8'h07, 1'b1, 1'b1);
    reg_read(2'd1, rd);
    check("parity ok STATUS", rd, 16'h0001);
    read_data_check("parity ok DATA");
`endif

    reg_read(2'd3, rd);
    check("reserved read", rd, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
